// File: rtl/adder_pkg.sv
// Shared constants and types for the six-operand adder datapath
// (parallel adder, serial accumulator and their checkers).
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_N_OPS = 6;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Width that holds the exact sum of n operands of w bits each.
    function automatic int unsigned sum_width(input int unsigned w, input int unsigned n);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/adder_serial_accum.sv
// Serial multi-operand adder: accumulates N_OPS operands from a valid/ready
// stream and returns the truncated sum plus its carry-out bits.
module adder_serial_accum
    import adder_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    parameter  int unsigned N_OPS = DEFAULT_N_OPS,
    localparam int unsigned CW    = $clog2(N_OPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [CW-1:0]    out_carry,
    output logic             busy
);

    localparam int unsigned SW = sum_width(WIDTH, N_OPS);

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [SW-1:0]    acc, acc_d;
    logic [SW-1:0]    sum_c;
    logic [WIDTH-1:0] result_d;
    logic [CW-1:0]    carry_d;
    logic             busy_d;

    assign in_ready = (state == COLLECT);

    // Next-state, accumulator and output-register update
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        acc_d    = acc;
        result_d = out_result;
        carry_d  = out_carry;
        sum_c    = acc + SW'(in_data);

        if (clr) begin
            state_d = COLLECT;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        if (cnt == CW'(N_OPS - 1)) begin
                            result_d = sum_c[WIDTH-1:0];
                            carry_d  = sum_c[SW-1:WIDTH];
                            state_d  = HOLD;
                            cnt_d    = '0;
                            acc_d    = '0;
                        end else begin
                            cnt_d = cnt + CW'(1);
                            acc_d = sum_c;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = COLLECT;
                    end
                end
            endcase
        end

        busy_d = (cnt_d != '0) || (state_d == HOLD);
    end

    // State and output registers; reset also clears the result data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= COLLECT;
            cnt        <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            acc        <= acc_d;
            out_valid  <= (state_d == HOLD);
            out_result <= result_d;
            out_carry  <= carry_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_adder_serial_accum.sv
// Bench for adder_serial_accum: operand-list model checked every cycle,
// plus literal expectations on each captured result.
module tb_adder_serial_accum;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N_OPS = 6;
    localparam int unsigned CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [CW-1:0]    out_carry;
    logic             busy;

    int checks = 0;
    int errors = 0;

    adder_serial_accum #(.WIDTH(WIDTH), .N_OPS(N_OPS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: list of accepted operands and the last produced sum
    bit m_known = 0;
    bit m_hold  = 0;
    int m_ops[$];
    int m_res   = 0;
    int got[$];

    always @(posedge clk) begin
        if (rst_n && !clr && out_valid && out_ready)
            got.push_back({13'd0, out_carry, out_result});

        if (!rst_n) begin
            m_known = 1;
            m_hold  = 0;
            m_ops.delete();
            m_res   = 0;
        end else if (clr) begin
            m_hold = 0;
            m_ops.delete();
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            m_ops.push_back(int'(in_data));
            if (m_ops.size() == N_OPS) begin
                m_res = 0;
                foreach (m_ops[i]) m_res += m_ops[i];
                m_hold = 1;
                m_ops.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("in_ready",   int'(in_ready),   int'(!m_hold));
            chk("out_valid",  int'(out_valid),  int'(m_hold));
            chk("busy",       int'(busy),       int'(m_hold || m_ops.size() != 0));
            chk("out_result", int'(out_result), m_res % 65536);
            chk("out_carry",  int'(out_carry),  m_res / 65536);
        end
    end

    // Present one operand and hold it until the block accepts it
    task automatic send(input logic [WIDTH-1:0] d);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", n, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_results(input int cnt);
        int n = 0;
        while (got.size() < cnt && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("result_count", got.size(), cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),   1);
        chk("rst_out_valid", int'(out_valid),  0);
        chk("rst_result",    int'(out_result), 0);
        chk("rst_carry",     int'(out_carry),  0);
        chk("rst_busy",      int'(busy),       0);
        @(posedge clk); #1;

        // 0..5 back to back
        for (int i = 0; i < 6; i++) send(16'(i));
        chk("t1_latency", int'(out_valid), 1);
        wait_results(1);
        chk("t1_sum", got[0], 'h0000F);

        // all-ones operands
        for (int i = 0; i < 6; i++) send(16'hFFFF);
        wait_results(2);
        chk("t2_full_sum", got[1], 'h5FFFA);
        chk("t2_result", got[1] & 'hFFFF, 'hFFFA);
        chk("t2_carry", got[1] >> 16, 5);

        // backpressure with a waiting operand
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(16'h0003);
        in_valid = 1'b1;
        in_data  = 16'h0009;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_stall_ready", int'(in_ready), 0);
            chk("t3_stall_result", int'(out_result), 'h12);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(16'h0009);
        for (int i = 0; i < 5; i++) send(16'h0001);
        wait_results(4);
        chk("t3_held_sum", got[2], 'h12);
        chk("t3_fresh_sum", got[3], 'h0E);

        // bubbles between operands
        for (int i = 0; i < 6; i++) begin
            send(16'h1000);
            idle(2);
        end
        wait_results(5);
        chk("t4_sum", got[4], 'h06000);

        // reset mid-sum
        for (int i = 0; i < 3; i++) send(16'h0007);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("t5_no_partial", got.size(), 5);
        for (int i = 0; i < 6; i++) send(16'h0001);
        wait_results(6);
        chk("t5_sum", got[5], 'h00006);

        // clr drops the sixth operand
        for (int i = 0; i < 5; i++) send(16'h0003);
        in_valid = 1'b1;
        in_data  = 16'h0003;
        clr      = 1'b1;
        idle(1);
        clr      = 1'b0;
        in_valid = 1'b0;
        idle(3);
        chk("t6_dropped", got.size(), 6);
        chk("t6_no_valid", int'(out_valid), 0);
        for (int i = 0; i < 6; i++) send(16'h0002);
        wait_results(7);
        chk("t6_sum", got[6], 'h0000C);

        idle(3);
        chk("total_results", got.size(), 7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_serial_accum.md
# adder_serial_accum

Serial multi-operand adder on the producer side of the six-operand adder datapath. It accepts operands one per cycle over a valid/ready stream, accumulates them, and returns the sum plus its carry-out bits over a second valid/ready stream. It serves callers that cannot present all six operands in parallel, with the same arithmetic result (A+B+C+D+E+F truncated to 16 bits), and adds the overflow bits the parallel adder discards.

## Interface
- WIDTH, 16, operand and result width
- N_OPS, 6, operands per sum (≥2)
- CW, $clog2(N_OPS), carry-out width (derived, not overridable)

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- clr  in  1  synchronous abort: discard partial sum or pending result
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operand
- in_data  in  WIDTH  operand, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  low WIDTH bits of sum
- out_carry  out  CW  bits [WIDTH+CW-1:WIDTH] of full sum
- busy  out  1  at least one operand accepted, result not yet consumed

## Operation
- States: COLLECT, HOLD.
- COLLECT: in_ready=1, out_valid=0. On in_valid&&in_ready: acc += in_data (WIDTH+CW-bit, no wrap), cnt++. When the N_OPS-th operand is accepted: latch acc+in_data into the output registers, go to HOLD, reset cnt and acc to 0.
- HOLD: in_ready=0, out_valid=1. out_result and out_carry stay stable until out_valid&&out_ready, then go to COLLECT.
- Arithmetic: the full sum is exact within WIDTH+CW bits. Max sum N_OPS·(2^WIDTH−1) fits, so no wrap ever occurs. out_result equals the sum mod 2^WIDTH.
- busy = (cnt≠0) || state==HOLD.
- clr (when rst_n=1): next state COLLECT, cnt=0, acc=0, out_valid=0. Any operand presented in the same cycle is dropped. clr has priority over every handshake.
- Reset (rst_n=0 at an edge): same effect as clr, and output data registers go to 0. Takes effect mid-operation with no partial result emitted.
- in_valid with in_ready=0 is ignored. The producer must hold data until accepted (standard valid/ready; valid must not depend on ready).

## Timing
- Reset values: in_ready=1 (after the first reset edge), out_valid=0, out_result=0, out_carry=0, busy=0.
- Latency: out_valid rises on the edge that accepts the N_OPS-th operand, i.e. the cycle after that operand is presented.
- Throughput: at most one result every N_OPS+1 cycles. The HOLD-to-COLLECT cycle never accepts an operand, even if out_ready and in_valid are both high.
- Gaps in in_valid (bubbles) are allowed anywhere in the sequence and do not change the sum.
- Operand accepted and out handshake in the same cycle is impossible by construction (in_ready=0 in HOLD).
- All outputs are registered except in_ready, which is decoded from state only.

## Structure
- Shared package adder_pkg:
  - default WIDTH/N_OPS constants
  - state enum typedef (COLLECT, HOLD)
  - function for the full-sum width WIDTH+$clog2(N_OPS), reused by the parallel adder's checker
- No sub-module. The operand counter and accumulator stay inline in one always_ff plus one small always_comb.

## Test plan
- Reset, then present 0,1,2,3,4,5 on consecutive cycles, out_ready=1 → out_valid one cycle after the last operand; out_result=0x000F, out_carry=0, matching the parallel adder.
- Six operands of 0xFFFF → out_result=0xFFFA, out_carry=5. Check that the 19-bit full sum equals 0x5FFFA.
- Result ready, out_ready held low 4 cycles with in_valid=1 → in_ready=0 throughout, result stable. After out_ready=1, the next accepted operand starts a fresh sum.
- Operands 0x1000×6 with random in_valid bubbles (e.g. 2 idle cycles between each) → out_result=0x6000, out_carry=0, busy high from first accept to consume.
- Accept 3 operands of 0x0007, assert rst_n=0 one cycle, then six operands of 0x0001 → no result before reset, then out_result=0x0006.
- Accept 5 operands, assert clr together with a 6th in_valid → operand dropped, no out_valid. Then six operands 0x0002 → out_result=0x000C.
